// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//
// Purpose:
//   Shares one Wishbone slave port between two pipeline masters. m0 is the
//   instruction fetch unit and m1 is the data memory stage. Ownership is
//   granted for whole bus cycles: once a master owns the bus, it keeps the
//   bus until it drops its cyc. The owner's request is routed to the slave,
//   and the slave response is returned only to the owner. The non-owner is
//   held off by its own busy logic, because it never sees an ack.
//
// Configuration:
//   WB_ARB_RR_EN  When defined, simultaneous requests are resolved
//                 round-robin (the master that was not granted last wins).
//                 When undefined, fixed priority is used and m1 (data) wins.
//
// Ports:
//   clk, reset              system clock; asynchronous active-high reset
//   m0_* / m1_*             master-side Wishbone signals
//                           (cyc, stb, we, adr, dat, sel in; ack, dat out)
//   s_*                     slave-side Wishbone signals
//                           (cyc, stb, we, adr, dat, sel out; ack, dat in)
//   grant_o                 one-hot owner: 01 = m0, 10 = m1, 00 = none
//   busy_o                  1 while any master owns the bus
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  // fetch master
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic                    m0_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  // data-memory master
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic                    m1_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  // shared slave
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  // status
  output logic [1:0]              grant_o,
  output logic                    busy_o
);

  // The encoding matches grant_o directly; 2'b11 is unreachable.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_OWN_M0 = 2'b01;
  localparam logic [1:0] ST_OWN_M1 = 2'b10;

  logic [1:0] state_q, state_d;
  logic [1:0] pick;
  logic       own_m0, own_m1;

  assign own_m0 = (state_q == ST_OWN_M0);
  assign own_m1 = (state_q == ST_OWN_M1);

`ifdef WB_ARB_RR_EN
  // 0 = m0 was granted last, 1 = m1 was granted last.
  logic last_owner_q;
`endif

  // Choose among the current requesters. This result is used only when the
  // bus is free, or when the owner is releasing it at this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path leaves it unassigned and infers a latch.
    pick = ST_IDLE;
    if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_RR_EN
      pick = last_owner_q ? ST_OWN_M0 : ST_OWN_M1;
`else
      pick = ST_OWN_M1;
`endif
    end else if (m1_cyc_i) begin
      pick = ST_OWN_M1;
    end else if (m0_cyc_i) begin
      pick = ST_OWN_M0;
    end
  end

  // The owner keeps the grant while its cyc is high. When the owner releases
  // its cyc, the next owner is picked at the same edge, so no idle bubble is
  // inserted during a handoff.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = pick;
      ST_OWN_M0: if (!m0_cyc_i) state_d = pick;
      ST_OWN_M1: if (!m1_cyc_i) state_d = pick;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: registered state uses non-blocking assignments, so every flop samples pre-edge values.
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef WB_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= 1'b0;
    end else if (state_d != state_q && state_d != ST_IDLE) begin
      last_owner_q <= (state_d == ST_OWN_M1);
    end
  end
`endif

  // Request mux. It depends only on state_q, so a master that drops cyc
  // before its ack removes s_cyc/s_stb in the same cycle. Asserting reset
  // also clears every slave-side output immediately.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (own_m0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (own_m1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // Response mux. An ack that arrives while the bus is idle, for example
  // after an abort, is discarded and is not forwarded to either master.
  assign m0_ack_o = s_ack_i & own_m0;
  assign m1_ack_o = s_ack_i & own_m1;
  assign m0_dat_o = own_m0 ? s_dat_i : '0;
  assign m1_dat_o = own_m1 ? s_dat_i : '0;

  assign grant_o = {own_m1, own_m0};
  assign busy_o  = own_m0 | own_m1;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard: each entry is the expected master (0 or 1) and read data.
  typedef struct {
    logic        who;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // Response monitor. Every ack seen by a master must match the head of the scoreboard.
  always @(negedge clk) begin
    if (m0_ack_o || m1_ack_o) begin
      tests_run++;
      if (m0_ack_o && m1_ack_o) begin
        tests_failed++;
        $display("FAIL ack_both: m0_ack=%b m1_ack=%b, want only one", m0_ack_o, m1_ack_o);
      end else if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL ack_unexpected: m0_ack=%b m1_ack=%b, want no ack", m0_ack_o, m1_ack_o);
      end else begin
        mon_e = sb.pop_front();
        if (m1_ack_o !== mon_e.who ||
            (m1_ack_o ? m1_dat_o : m0_dat_o) !== mon_e.data ||
            (m1_ack_o ? m0_dat_o : m1_dat_o) !== 32'h0) begin
          tests_failed++;
          $display("FAIL ack_resp: got m%0d dat=%h other_dat=%h, want m%0d dat=%h other_dat=0",
                   m1_ack_o, m1_ack_o ? m1_dat_o : m0_dat_o,
                   m1_ack_o ? m0_dat_o : m1_dat_o, mon_e.who, mon_e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1234_5678;
    #3;
    tests_run++;
    if (grant_o !== 2'b00 || busy_o !== 1'b0 || s_cyc_o !== 1'b0 || s_adr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: grant=%b busy=%b s_cyc=%b s_adr=%h, want 00/0/0/0",
               grant_o, busy_o, s_cyc_o, s_adr_o);
    end
    step();
    idle_inputs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_m0();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h8000_0000; m0_sel_i = 4'hF;
    #1;
    tests_run++;
    if (s_cyc_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_latency: s_cyc=%b before grant edge, want 0", s_cyc_o);
    end
    step();
    tests_run++;
    if (grant_o !== 2'b01 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL read_grant: grant=%b s_cyc=%b s_stb=%b s_adr=%h, want 01/1/1/80000000",
               grant_o, s_cyc_o, s_stb_o, s_adr_o);
    end
    step();
    step();
    s_ack_i = 1; s_dat_i = 32'h0000_0013;
    sb.push_back('{who: 1'b0, data: 32'h0000_0013});
    #1;
    tests_run++;
    if (m1_ack_o !== 1'b0 || m0_dat_o !== 32'h13) begin
      tests_failed++;
      $display("FAIL read_resp: m1_ack=%b m0_dat=%h, want 0/00000013", m1_ack_o, m0_dat_o);
    end
    step();
    s_ack_i = 0; s_dat_i = '0;
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    tests_run++;
    if (grant_o !== 2'b00 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_release: grant=%b busy=%b, want 00/0", grant_o, busy_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] want;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h8000_0000;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h8040_0000;
    step();
    // Both modes pick m1 here: fixed priority selects m1, and round-robin
    // last granted m0.
    tests_run++;
    if (grant_o !== 2'b10 || s_adr_o !== 32'h8040_0000) begin
      tests_failed++;
      $display("FAIL simul_first: grant=%b s_adr=%h, want 10/80400000", grant_o, s_adr_o);
    end
    s_ack_i = 1; s_dat_i = 32'hAAAA_0001;
    sb.push_back('{who: 1'b1, data: 32'hAAAA_0001});
    step();
    s_ack_i = 0; s_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    tests_run++;
    if (grant_o !== 2'b01 || s_adr_o !== 32'h8000_0000 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL handoff: grant=%b s_adr=%h busy=%b, want 01/80000000/1", grant_o, s_adr_o, busy_o);
    end
    s_ack_i = 1; s_dat_i = 32'hBBBB_0002;
    sb.push_back('{who: 1'b0, data: 32'hBBBB_0002});
    step();
    s_ack_i = 0; s_dat_i = '0;
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    // Make m1 the last owner. Then request from both masters together.
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    m0_cyc_i = 1; m0_stb_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
`ifdef WB_ARB_RR_EN
    want = 2'b01;
`else
    want = 2'b10;
`endif
    tests_run++;
    if (grant_o !== want) begin
      tests_failed++;
      $display("FAIL simul_policy: grant=%b, want %b", grant_o, want);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    apply_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0200;
    step();
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      tests_run++;
      if (grant_o !== want) begin
        tests_failed++;
        $display("FAIL rr_seq[%0d]: grant=%b, want %b", i, grant_o, want);
      end
      s_ack_i = 1; s_dat_i = 32'h100 + i;
      sb.push_back('{who: want[1], data: 32'h100 + i});
      step();
      s_ack_i = 0; s_dat_i = '0;
      if (want[1]) begin m1_cyc_i = 0; m1_stb_i = 0; end
      else         begin m0_cyc_i = 0; m0_stb_i = 0; end
      step();
      m0_cyc_i = 1; m0_stb_i = 1;
      m1_cyc_i = 1; m1_stb_i = 1;
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_flush();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h8000_0040;
    step();
    m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    tests_run++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_comb: s_cyc=%b s_stb=%b grant=%b, want 0/0/01", s_cyc_o, s_stb_o, grant_o);
    end
    step();
    tests_run++;
    if (grant_o !== 2'b00 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_release: grant=%b busy=%b, want 00/0", grant_o, busy_o);
    end
    s_ack_i = 1; s_dat_i = 32'hFFFF_FFFF;
    #1;
    tests_run++;
    if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL stray_ack: m0_ack=%b m1_ack=%b m0_dat=%h m1_dat=%h, want all 0",
               m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_write_and_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'b0011;
    m1_dat_i = 32'hDEAD_BEEF; m1_adr_i = 32'h1000_0000;
    step();
    tests_run++;
    if (s_we_o !== 1'b1 || s_sel_o !== 4'b0011 || s_dat_o !== 32'hDEAD_BEEF ||
        s_adr_o !== 32'h1000_0000 || grant_o !== 2'b10) begin
      tests_failed++;
      $display("FAIL write_route: we=%b sel=%b dat=%h adr=%h grant=%b, want 1/0011/deadbeef/10000000/10",
               s_we_o, s_sel_o, s_dat_o, s_adr_o, grant_o);
    end
    #2;
    reset = 1'b1;
    s_ack_i = 1;
    #1;
    tests_run++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0 || s_adr_o !== 32'h0 ||
        s_dat_o !== 32'h0 || s_sel_o !== 4'h0 || grant_o !== 2'b00 || busy_o !== 1'b0 ||
        m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midcycle_reset: s_cyc=%b we=%b adr=%h grant=%b busy=%b m1_ack=%b, want all 0",
               s_cyc_o, s_we_o, s_adr_o, grant_o, busy_o, m1_ack_o);
    end
    step();
    idle_inputs();
    reset = 1'b0;
    step();
    tests_run++;
    if (grant_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL post_reset_idle: grant=%b, want 00", grant_o);
    end
  endtask

  initial begin
    test_reset();
    test_read_m0();
    test_simultaneous();
    test_back_to_back();
    test_flush();
    test_write_and_reset();
    step();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d expected acks never seen, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
